inst_fetch: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and issues one instruction-memory read at a time. Presents each returned word with its PC on a valid/stall interface whose data output drives the decoder's `i_inst_data`. Absorbs back-pressure with a one-entry skid buffer and discards in-flight fetches on branch/jump redirect.

---
 rtl/inst_fetch.sv | 153 +++++++++++++++
 tb/tb_inst_fetch.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem read, output register
// with one-entry skid buffer, and redirect handling that discards in-flight reads.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic        i_imem_valid,
   input  logic [31:0] i_imem_data,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_inst_valid,
   output logic [31:0] o_inst_data,
   output logic [31:0] o_inst_pc
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_FULL} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   req_pc_q, req_pc_d;
   logic              or_valid_q, or_valid_d;
   logic [XLEN-1:0]   or_data_q, or_data_d;
   logic [XLEN-1:0]   or_pc_q, or_pc_d;
   logic [XLEN-1:0]   sb_data_q, sb_data_d;
   logic [XLEN-1:0]   sb_pc_q, sb_pc_d;
   logic              kill_q, kill_d;

   logic              req_c;
   logic              accept_c;
   logic              consume_c;

   assign req_c       = (state_q == S_REQ) & ~i_redirect;
   assign accept_c    = req_c & i_imem_ready;
   assign consume_c   = or_valid_q & ~i_stall;

   assign o_imem_req   = req_c;
   assign o_imem_addr  = fetch_pc_q;
   assign o_inst_valid = or_valid_q;
   assign o_inst_data  = or_data_q;
   assign o_inst_pc    = or_pc_q;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= S_BOOT;
      else       state_q <= state_d;
   end

   // Next-state logic; redirect overrides everything except an empty wait
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BOOT: state_d = S_REQ;
         S_REQ:  if (accept_c) state_d = S_WAIT;
         S_WAIT: begin
            if (i_imem_valid) begin
               if (kill_q || !or_valid_q || consume_c) state_d = S_REQ;
               else                                    state_d = S_FULL;
            end
         end
         S_FULL: if (consume_c) state_d = S_REQ;
         default: state_d = S_BOOT;
      endcase
      if (i_redirect) begin
         if (state_q == S_WAIT && !i_imem_valid) state_d = S_WAIT;
         else                                    state_d = S_REQ;
      end
   end

   // Datapath next values: PC advance, OR/SB loads, kill tracking
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      or_valid_d = or_valid_q;
      or_data_d  = or_data_q;
      or_pc_d    = or_pc_q;
      sb_data_d  = sb_data_q;
      sb_pc_d    = sb_pc_q;
      kill_d     = kill_q;
      if (i_redirect) begin
         fetch_pc_d = i_redirect_pc & ~XLEN'(3);
         or_valid_d = 1'b0;
         or_data_d  = NOP_INST;
         kill_d     = (state_q == S_WAIT) && !i_imem_valid;
      end else begin
         if (consume_c) begin
            or_valid_d = 1'b0;
            or_data_d  = NOP_INST;
         end
         case (state_q)
            S_REQ: begin
               if (accept_c) begin
                  req_pc_d   = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + XLEN'(4);
               end
            end
            S_WAIT: begin
               if (i_imem_valid) begin
                  if (kill_q) begin
                     kill_d = 1'b0;
                  end else if (!or_valid_q || consume_c) begin
                     or_valid_d = 1'b1;
                     or_data_d  = i_imem_data;
                     or_pc_d    = req_pc_q;
                  end else begin
                     sb_data_d = i_imem_data;
                     sb_pc_d   = req_pc_q;
                  end
               end
            end
            S_FULL: begin
               if (consume_c) begin
                  or_valid_d = 1'b1;
                  or_data_d  = sb_data_q;
                  or_pc_d    = sb_pc_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         or_valid_q <= 1'b0;
         or_data_q  <= NOP_INST;
         or_pc_q    <= '0;
         sb_data_q  <= '0;
         sb_pc_q    <= '0;
         kill_q     <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         or_valid_q <= or_valid_d;
         or_data_q  <= or_data_d;
         or_pc_q    <= or_pc_d;
         sb_data_q  <= sb_data_d;
         sb_pc_q    <= sb_pc_d;
         kill_q     <= kill_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed scenarios push expected (pc, data)
// pairs; a monitor pops and compares on every consumed instruction.
module tb_inst_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_data = 32'h0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   logic        w_req;
   logic [31:0] w_addr;
   logic        w_valid = 1'b0;
   logic [31:0] w_data = 32'h0;
   logic        w_ivalid;
   logic [31:0] w_idata;
   logic [31:0] w_pc;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   acc_cnt = 0;
   int   budget = 0;
   int   lat = 1;
   bit   w_done = 1'b0;

   always #5 clk = ~clk;

   inst_fetch dut (
      .i_clk(clk), .i_rst(rst),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr),
      .i_imem_ready(imem_ready), .i_imem_valid(imem_valid), .i_imem_data(imem_data),
      .i_stall(stall), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_inst_valid(inst_valid), .o_inst_data(inst_data), .o_inst_pc(inst_pc)
   );

   inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
      .i_clk(clk), .i_rst(rst),
      .o_imem_req(w_req), .o_imem_addr(w_addr),
      .i_imem_ready(1'b1), .i_imem_valid(w_valid), .i_imem_data(w_data),
      .i_stall(1'b0), .i_redirect(1'b0), .i_redirect_pc(32'h0),
      .o_inst_valid(w_ivalid), .o_inst_data(w_idata), .o_inst_pc(w_pc)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic push(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.data = ~pc;
      sb_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input int l, input int b);
      rst = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      lat = l;
      budget = b;
      sb_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req", 32'(imem_req), 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", 32'(inst_valid), 32'h0);
      check("rst_data", inst_data, NOP);
      check("rst_pc", inst_pc, 32'h0);
      rst = 1'b0;
   endtask

   task automatic wait_acc(input int n, input string nm);
      for (int i = 0; i < 100; i++) begin
         if (acc_cnt >= n) break;
         step();
      end
      check(nm, 32'(acc_cnt >= n), 32'h1);
   endtask

   task automatic wait_empty(input int maxcyc, input string nm);
      for (int i = 0; i < maxcyc; i++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      check(nm, 32'(sb_q.size()), 32'h0);
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_accept_addr(input logic [31:0] exp, input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (imem_req && imem_ready) begin
            seen = 1'b1;
            break;
         end
      end
      check({nm, "_seen"}, 32'(seen), 32'h1);
      check(nm, imem_addr, exp);
   endtask

   // Instruction memory model: configurable latency, accept budget, data = ~addr
   initial begin : mem_model
      logic        acc;
      logic [31:0] a_s;
      logic        del;
      logic        pend;
      logic [31:0] paddr;
      int          cnt;
      pend = 1'b0;
      paddr = 32'h0;
      cnt = 0;
      forever begin
         @(negedge clk);
         acc = imem_req & imem_ready;
         a_s = imem_addr;
         del = imem_valid;
         @(posedge clk);
         #1;
         if (rst) begin
            pend = 1'b0;
            imem_valid = 1'b0;
            acc_cnt = 0;
         end else begin
            if (del) begin
               imem_valid = 1'b0;
               pend = 1'b0;
            end
            if (acc) begin
               pend = 1'b1;
               paddr = a_s;
               cnt = lat - 1;
               acc_cnt++;
            end else if (pend && cnt > 0) begin
               cnt--;
            end
            if (pend && cnt == 0) begin
               imem_valid = 1'b1;
               imem_data = ~paddr;
            end
         end
         imem_ready = (acc_cnt < budget);
      end
   end

   // Memory for the wrap instance: always ready, one-cycle response
   initial begin : w_mem
      logic        s;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         s = w_req;
         a = w_addr;
         @(posedge clk);
         #1;
         if (rst) begin
            w_valid = 1'b0;
         end else begin
            w_valid = s;
            w_data = ~a;
         end
      end
   end

   // Monitor: scoreboard pops on consume, stall stability, NOP when idle
   initial begin : monitor
      logic        hold;
      logic [31:0] hpc;
      logic [31:0] hdat;
      exp_t        e;
      hold = 1'b0;
      hpc = 32'h0;
      hdat = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 1'b0;
         end else begin
            if (redirect) check("req_in_redirect", 32'(imem_req), 32'h0);
            if (hold) begin
               check("stall_valid", 32'(inst_valid), 32'h1);
               check("stall_pc", inst_pc, hpc);
               check("stall_data", inst_data, hdat);
            end
            if (!inst_valid) check("nop_when_invalid", inst_data, NOP);
            if (inst_valid && !stall) begin
               if (sb_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_output: got pc %h, expected no instruction", inst_pc);
               end else begin
                  e = sb_q.pop_front();
                  check("out_pc", inst_pc, e.pc);
                  check("out_data", inst_data, e.data);
               end
            end
            hold = inst_valid & stall & ~redirect;
            hpc = inst_pc;
            hdat = inst_data;
         end
      end
   end

   // Wrap-around instance: requests and outputs for FFFF_FFF8, FFFF_FFFC, 0
   initial begin : wrap_chk
      logic [31:0] ea [3];
      int na;
      int no;
      ea[0] = 32'hFFFF_FFF8;
      ea[1] = 32'hFFFF_FFFC;
      ea[2] = 32'h0000_0000;
      na = 0;
      no = 0;
      wait (rst == 1'b0);
      for (int i = 0; i < 40 && (na < 3 || no < 3); i++) begin
         @(negedge clk);
         if (w_req && na < 3) begin
            check("wrap_addr", w_addr, ea[na]);
            na++;
         end
         if (w_ivalid && no < 3) begin
            check("wrap_pc", w_pc, ea[no]);
            no++;
         end
      end
      if (na < 3 || no < 3) begin
         n_chk++;
         $display("FAIL wrap_timeout: got %0d requests and %0d outputs, expected 3 and 3", na, no);
      end
      w_done = 1'b1;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [8:0] pat;

      // Free run: PCs 0,4,8,12, valid every other cycle after 2-cycle latency
      do_reset(1, 4);
      push(32'h0); push(32'h4); push(32'h8); push(32'hC);
      pat = 9'b101010100;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("t1_first_req", 32'(imem_req), 32'h1);
            check("t1_first_addr", imem_addr, 32'h0);
         end
         check("t1_valid_pattern", 32'(inst_valid), 32'(pat[i]));
      end
      wait_empty(40, "t1_drain");
      for (int i = 0; i < 100 && !w_done; i++) @(negedge clk);
      check("wrap_done", 32'(w_done), 32'h1);

      // Stall: second word parks in SB, no third request until release
      do_reset(1, 4);
      stall = 1'b1;
      push(32'h0); push(32'h4); push(32'h8); push(32'hC);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (inst_valid) break;
      end
      repeat (4) @(negedge clk);
      check("t2_acc_held", 32'(acc_cnt), 32'd2);
      check("t2_no_req", 32'(imem_req), 32'h0);
      check("t2_or_pc", inst_pc, 32'h0);
      step();
      stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t2_sb_pc", inst_pc, 32'h4);
      check("t2_next_req", 32'(imem_req), 32'h1);
      check("t2_next_addr", imem_addr, 32'h8);
      wait_empty(40, "t2_drain");

      // Redirect in S_WAIT with a late response: old word is killed
      do_reset(4, 3);
      push(32'h100); push(32'h104);
      wait_acc(1, "t3_first_acc");
      redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      step();
      redirect = 1'b0;
      @(negedge clk);
      check("t3_valid_after_redirect", 32'(inst_valid), 32'h0);
      check("t3_addr_aligned", imem_addr, 32'h100);
      wait_accept_addr(32'h100, "t3_req_addr");
      wait_empty(60, "t3_drain");

      // Redirect coincident with response while stalled, then again with SB full
      do_reset(1, 5);
      stall = 1'b1;
      push(32'h300);
      wait_acc(2, "t4_acc2");
      check("t4_resp_coincident", 32'(imem_valid), 32'h1);
      redirect = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      @(negedge clk);
      check("t4_valid_after_redirect1", 32'(inst_valid), 32'h0);
      wait_acc(4, "t4_acc4");
      step();
      step();
      check("t4_full_or_pc", inst_pc, 32'h200);
      redirect = 1'b1;
      redirect_pc = 32'h300;
      step();
      redirect = 1'b0;
      stall = 1'b0;
      @(negedge clk);
      check("t4_valid_after_redirect2", 32'(inst_valid), 32'h0);
      wait_empty(40, "t4_drain");

      // Asynchronous reset mid-wait with a live instruction held
      do_reset(3, 10);
      stall = 1'b1;
      wait_acc(2, "t6_acc2");
      check("t6_pre_valid", 32'(inst_valid), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check("t6_async_valid", 32'(inst_valid), 32'h0);
      check("t6_async_data", inst_data, NOP);
      check("t6_async_pc", inst_pc, 32'h0);
      check("t6_async_req", 32'(imem_req), 32'h0);
      check("t6_async_addr", imem_addr, 32'h0);
      do_reset(1, 1);
      push(32'h0);
      wait_accept_addr(32'h0, "t6_restart_addr");
      wait_empty(40, "t6_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
